// File: rtl/estacao_reserva.sv
// rtl/estacao_reserva.sv - Tomasulo reservation station with CDB snooping and round-robin dispatch
//
// Holds DEPTH entries (op, Vj/Vk, Qj/Qk); pending operands are resolved by snooping
// the CDB, and one READY entry per cycle is moved into a registered dispatch slot.
// An entry keeps its tag reserved until its own result is broadcast on the CDB.
//
// Ports:
//   Clock, Reset                  rising-edge clock, asynchronous active-low reset
//   Issue_valid/Issue_ready       issue handshake; Issue_ready = some entry FREE
//   Issue_op/Vj/Vk/Qj/Qk          issued instruction; Q = producer tag, 0 = value valid
//   Issue_tag                     tag of the entry that would accept this issue
//   CDB_valid/Qi_CDB/Qi_CDB_data  common data bus broadcast
//   Disp_valid/Disp_ready         registered dispatch handshake towards the UF
//   Disp_op/Vj/Vk/tag             dispatch payload
//   Full                          no FREE entry
module estacao_reserva #(
   parameter int                 DEPTH       = 3,
   parameter int                 DATA_W      = 16,
   parameter int                 TAG_W       = 3,
   parameter int                 OP_W        = 4,
   parameter logic [TAG_W-1:0]   RS_TAG_BASE = 3'd1,
   parameter logic [DATA_W-1:0]  V_SEM_VALOR = 16'hFFF0,
   parameter logic [TAG_W-1:0]   Q_SEM_VALOR = 3'b000
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Issue_valid,
   output logic              Issue_ready,
   input  logic [OP_W-1:0]   Issue_op,
   input  logic [DATA_W-1:0] Issue_Vj,
   input  logic [DATA_W-1:0] Issue_Vk,
   input  logic [TAG_W-1:0]  Issue_Qj,
   input  logic [TAG_W-1:0]  Issue_Qk,
   output logic [TAG_W-1:0]  Issue_tag,
   input  logic              CDB_valid,
   input  logic [TAG_W-1:0]  Qi_CDB,
   input  logic [DATA_W-1:0] Qi_CDB_data,
   output logic              Disp_valid,
   input  logic              Disp_ready,
   output logic [OP_W-1:0]   Disp_op,
   output logic [DATA_W-1:0] Disp_Vj,
   output logic [DATA_W-1:0] Disp_Vk,
   output logic [TAG_W-1:0]  Disp_tag,
   output logic              Full
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_FREE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;
   localparam logic [1:0] S_EXEC  = 2'd3;

   logic [1:0]        st   [DEPTH];
   logic [1:0]        st_n [DEPTH];
   logic [OP_W-1:0]   op   [DEPTH];
   logic [OP_W-1:0]   op_n [DEPTH];
   logic [DATA_W-1:0] vj   [DEPTH];
   logic [DATA_W-1:0] vj_n [DEPTH];
   logic [DATA_W-1:0] vk   [DEPTH];
   logic [DATA_W-1:0] vk_n [DEPTH];
   logic [TAG_W-1:0]  qj   [DEPTH];
   logic [TAG_W-1:0]  qj_n [DEPTH];
   logic [TAG_W-1:0]  qk   [DEPTH];
   logic [TAG_W-1:0]  qk_n [DEPTH];

   logic              dv_q, dv_n;
   logic [OP_W-1:0]   dop_q, dop_n;
   logic [DATA_W-1:0] dvj_q, dvj_n, dvk_q, dvk_n;
   logic [TAG_W-1:0]  dtag_q, dtag_n;
   logic [IDX_W-1:0]  last_q, last_n;

   logic              free_found, ready_found;
   logic [IDX_W-1:0]  free_idx, sel_idx;
   int                rr_idx;

   // Issue slot (lowest-index FREE) and round-robin pick among READY entries.
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      ready_found = 1'b0;
      sel_idx     = '0;
      rr_idx      = 0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (st[i] == S_FREE) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      for (int k = 1; k <= DEPTH; k++) begin
         rr_idx = (int'(last_q) + k) % DEPTH;
         if (!ready_found && st[rr_idx] == S_READY) begin
            ready_found = 1'b1;
            sel_idx     = IDX_W'(rr_idx);
         end
      end
      Issue_ready = free_found;
      Full        = !free_found;
      Issue_tag   = RS_TAG_BASE + TAG_W'(free_idx);
   end

   // Next-state for every entry and for the dispatch register.
   always_comb begin
      logic              issue_fire, load;
      logic [DATA_W-1:0] bvj, bvk;
      logic [TAG_W-1:0]  bqj, bqk;

      st_n   = st;
      op_n   = op;
      vj_n   = vj;
      vk_n   = vk;
      qj_n   = qj;
      qk_n   = qk;
      dv_n   = dv_q;
      dop_n  = dop_q;
      dvj_n  = dvj_q;
      dvk_n  = dvk_q;
      dtag_n = dtag_q;
      last_n = last_q;

      issue_fire = Issue_valid && free_found;
      load       = !dv_q || Disp_ready;

      // Same-cycle bypass: an operand whose producer is broadcasting right now is captured directly.
      bvj = Issue_Vj;
      bqj = Issue_Qj;
      bvk = Issue_Vk;
      bqk = Issue_Qk;
      if (CDB_valid && Issue_Qj != Q_SEM_VALOR && Issue_Qj == Qi_CDB) begin
         bvj = Qi_CDB_data;
         bqj = Q_SEM_VALOR;
      end
      if (CDB_valid && Issue_Qk != Q_SEM_VALOR && Issue_Qk == Qi_CDB) begin
         bvk = Qi_CDB_data;
         bqk = Q_SEM_VALOR;
      end

      if (load)
         dv_n = ready_found;

      for (int i = 0; i < DEPTH; i++) begin
         case (st[i])
            S_WAIT: begin
               if (CDB_valid && qj[i] != Q_SEM_VALOR && qj[i] == Qi_CDB) begin
                  vj_n[i] = Qi_CDB_data;
                  qj_n[i] = Q_SEM_VALOR;
               end
               if (CDB_valid && qk[i] != Q_SEM_VALOR && qk[i] == Qi_CDB) begin
                  vk_n[i] = Qi_CDB_data;
                  qk_n[i] = Q_SEM_VALOR;
               end
               if (qj_n[i] == Q_SEM_VALOR && qk_n[i] == Q_SEM_VALOR)
                  st_n[i] = S_READY;
            end
            S_READY: begin
               if (load && ready_found && sel_idx == IDX_W'(i)) begin
                  st_n[i] = S_EXEC;
                  dop_n   = op[i];
                  dvj_n   = vj[i];
                  dvk_n   = vk[i];
                  dtag_n  = RS_TAG_BASE + TAG_W'(i);
                  last_n  = IDX_W'(i);
               end
            end
            S_EXEC: begin
               // The tag stays reserved until the UF broadcasts this entry's own result.
               if (CDB_valid && Qi_CDB == RS_TAG_BASE + TAG_W'(i))
                  st_n[i] = S_FREE;
            end
            default: begin
               if (issue_fire && free_idx == IDX_W'(i)) begin
                  op_n[i] = Issue_op;
                  vj_n[i] = bvj;
                  vk_n[i] = bvk;
                  qj_n[i] = bqj;
                  qk_n[i] = bqk;
                  st_n[i] = (bqj == Q_SEM_VALOR && bqk == Q_SEM_VALOR) ? S_READY : S_WAIT;
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            st[i] <= S_FREE;
            op[i] <= '0;
            vj[i] <= V_SEM_VALOR;
            vk[i] <= V_SEM_VALOR;
            qj[i] <= Q_SEM_VALOR;
            qk[i] <= Q_SEM_VALOR;
         end
         dv_q   <= 1'b0;
         dop_q  <= '0;
         dvj_q  <= '0;
         dvk_q  <= '0;
         dtag_q <= '0;
         last_q <= IDX_W'(DEPTH - 1);
      end else begin
         st     <= st_n;
         op     <= op_n;
         vj     <= vj_n;
         vk     <= vk_n;
         qj     <= qj_n;
         qk     <= qk_n;
         dv_q   <= dv_n;
         dop_q  <= dop_n;
         dvj_q  <= dvj_n;
         dvk_q  <= dvk_n;
         dtag_q <= dtag_n;
         last_q <= last_n;
      end
   end

   assign Disp_valid = dv_q;
   assign Disp_op    = dop_q;
   assign Disp_Vj    = dvj_q;
   assign Disp_Vk    = dvk_q;
   assign Disp_tag   = dtag_q;

endmodule

// File: tb/tb_estacao_reserva.sv
// tb/tb_estacao_reserva.sv - scoreboard bench for estacao_reserva
module tb_estacao_reserva;

   logic        Clock;
   logic        Reset;
   logic        Issue_valid;
   logic        Issue_ready;
   logic [3:0]  Issue_op;
   logic [15:0] Issue_Vj;
   logic [15:0] Issue_Vk;
   logic [2:0]  Issue_Qj;
   logic [2:0]  Issue_Qk;
   logic [2:0]  Issue_tag;
   logic        CDB_valid;
   logic [2:0]  Qi_CDB;
   logic [15:0] Qi_CDB_data;
   logic        Disp_valid;
   logic        Disp_ready;
   logic [3:0]  Disp_op;
   logic [15:0] Disp_Vj;
   logic [15:0] Disp_Vk;
   logic [2:0]  Disp_tag;
   logic        Full;

   estacao_reserva dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Issue_valid (Issue_valid),
      .Issue_ready (Issue_ready),
      .Issue_op    (Issue_op),
      .Issue_Vj    (Issue_Vj),
      .Issue_Vk    (Issue_Vk),
      .Issue_Qj    (Issue_Qj),
      .Issue_Qk    (Issue_Qk),
      .Issue_tag   (Issue_tag),
      .CDB_valid   (CDB_valid),
      .Qi_CDB      (Qi_CDB),
      .Qi_CDB_data (Qi_CDB_data),
      .Disp_valid  (Disp_valid),
      .Disp_ready  (Disp_ready),
      .Disp_op     (Disp_op),
      .Disp_Vj     (Disp_Vj),
      .Disp_Vk     (Disp_Vk),
      .Disp_tag    (Disp_tag),
      .Full        (Full)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected dispatch payload {op, Vj, Vk, tag}.
   logic [38:0] sb [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge Clock) begin
      if (Reset && Disp_valid && Disp_ready) begin
         if (sb.size() == 0) begin
            check("disp_unexpected", {25'd0, Disp_op, Disp_Vj, Disp_Vk, Disp_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check("disp_payload", {25'd0, Disp_op, Disp_Vj, Disp_Vk, Disp_tag}, {25'd0, sb.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_issue(input logic [3:0] op, input logic [15:0] vj, input logic [15:0] vk,
                           input logic [2:0] qj, input logic [2:0] qk);
      Issue_valid = 1'b1;
      Issue_op    = op;
      Issue_Vj    = vj;
      Issue_Vk    = vk;
      Issue_Qj    = qj;
      Issue_Qk    = qk;
      tick();
      Issue_valid = 1'b0;
      CDB_valid   = 1'b0;
   endtask

   task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
      CDB_valid   = 1'b1;
      Qi_CDB      = tag;
      Qi_CDB_data = data;
      tick();
      CDB_valid   = 1'b0;
   endtask

   initial begin
      Reset       = 1'b0;
      Issue_valid = 1'b0;
      Issue_op    = '0;
      Issue_Vj    = '0;
      Issue_Vk    = '0;
      Issue_Qj    = '0;
      Issue_Qk    = '0;
      CDB_valid   = 1'b0;
      Qi_CDB      = '0;
      Qi_CDB_data = '0;
      Disp_ready  = 1'b1;
      tick();
      tick();
      check("rst_disp_valid", Disp_valid, 0);
      check("rst_full", Full, 0);
      check("rst_issue_ready", Issue_ready, 1);
      check("rst_issue_tag", Issue_tag, 1);
      check("rst_disp_tag", Disp_tag, 0);
      Reset = 1'b1;
      tick();

      // Both operands valid: dispatch visible after the second edge.
      sb.push_back({4'd2, 16'd5, 16'd7, 3'd1});
      do_issue(4'd2, 16'd5, 16'd7, 3'd0, 3'd0);
      check("lat_one_edge", Disp_valid, 0);
      tick();
      check("lat_two_edges", Disp_valid, 1);
      check("exec_issue_tag", Issue_tag, 2);
      cdb(3'd1, 16'h0);
      check("freed_issue_tag", Issue_tag, 1);
      check("freed_ready", Issue_ready, 1);

      // Pending Vj resolved by a later CDB broadcast.
      sb.push_back({4'd3, 16'h0012, 16'd3, 3'd1});
      do_issue(4'd3, 16'hFFF0, 16'd3, 3'd4, 3'd0);
      tick();
      tick();
      check("pend_no_disp", Disp_valid, 0);
      cdb(3'd4, 16'h0012);
      check("snoop_not_yet", Disp_valid, 0);
      tick();
      check("snoop_disp", Disp_valid, 1);
      cdb(3'd1, 16'h0);

      // Same-cycle bypass of the issuing operand.
      sb.push_back({4'd4, 16'd9, 16'd1, 3'd1});
      CDB_valid   = 1'b1;
      Qi_CDB      = 3'd5;
      Qi_CDB_data = 16'd9;
      do_issue(4'd4, 16'hFFF0, 16'd1, 3'd5, 3'd0);
      tick();
      check("bypass_disp", Disp_valid, 1);
      check("bypass_vj", Disp_Vj, 16'd9);
      cdb(3'd1, 16'h0);

      // Fill all entries with the UF stalled.
      Disp_ready = 1'b0;
      sb.push_back({4'd5, 16'd1, 16'd1, 3'd1});
      sb.push_back({4'd6, 16'd2, 16'd2, 3'd2});
      sb.push_back({4'd7, 16'd3, 16'd3, 3'd3});
      do_issue(4'd5, 16'd1, 16'd1, 3'd0, 3'd0);
      do_issue(4'd6, 16'd2, 16'd2, 3'd0, 3'd0);
      do_issue(4'd7, 16'd3, 16'd3, 3'd0, 3'd0);
      check("full_set", Full, 1);
      check("full_not_ready", Issue_ready, 0);
      do_issue(4'd8, 16'd8, 16'd8, 3'd0, 3'd0);
      check("full_ignored", Full, 1);
      check("hold_op", Disp_op, 5);
      tick();
      tick();
      check("hold_valid", Disp_valid, 1);
      check("hold_payload", {Disp_op, Disp_Vj, Disp_Vk, Disp_tag}, {4'd5, 16'd1, 16'd1, 3'd1});
      Disp_ready = 1'b1;
      tick();
      tick();
      tick();
      tick();
      check("drain_valid", Disp_valid, 0);
      cdb(3'd1, 16'h0);
      check("reuse_tag", Issue_tag, 1);
      cdb(3'd2, 16'h0);
      cdb(3'd3, 16'h0);
      check("all_free", Full, 0);

      // Asynchronous reset in the middle of activity.
      Disp_ready = 1'b0;
      do_issue(4'd10, 16'd10, 16'd10, 3'd0, 3'd0);
      do_issue(4'd11, 16'd11, 16'd11, 3'd3, 3'd0);
      #2;
      Reset = 1'b0;
      #1;
      check("mid_rst_disp_valid", Disp_valid, 0);
      check("mid_rst_full", Full, 0);
      check("mid_rst_issue_tag", Issue_tag, 1);
      tick();
      Reset      = 1'b1;
      Disp_ready = 1'b1;
      sb.push_back({4'd9, 16'hAAAA, 16'h5555, 3'd1});
      do_issue(4'd9, 16'hAAAA, 16'h5555, 3'd0, 3'd0);
      tick();
      check("post_rst_disp", Disp_valid, 1);
      tick();
      tick();
      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
